reg_file_demux_32x32: RTL and testbench
=======================================

Name: reg_file_demux_32x32

Overview:
MIPS general-purpose register file, built around an explicit 1-to-32 write-enable demultiplexer. This is the write-side counterpart of the 2:1 select logic used elsewhere in the datapath: one writeback word is steered into one of 32 registers. Two read ports return rs/rt operands combinationally to the ALU and branch logic of the single-cycle core. Register $0 is hardwired to zero.

Parameters:
DATA_W, 32, register and port data width.
ADDR_W, 5, register index width; depth is 2**ADDR_W = 32.

Ports:
clk  input  1  core clock; all writes on rising edge.
rst  input  1  asynchronous, active-high reset; clears all registers.
wr_en  input  1  RegWrite from control unit.
wr_addr  input  ADDR_W  destination index (rd or rt, from the RegDst mux).
wr_data  input  DATA_W  writeback word (from the MemtoReg mux).
rd_addr1  input  ADDR_W  rs index.
rd_addr2  input  ADDR_W  rt index.
rd_data1  output  DATA_W  contents of register rd_addr1.
rd_data2  output  DATA_W  contents of register rd_addr2.

Behaviour:
- Reset: when rst is asserted, all 32 registers go to 0 immediately, with no wait for clk. Both rd_data outputs therefore read 0 while rst is high. Writes are ignored while rst is high.
- Write demux: decode wr_addr into a 32-bit one-hot vector, gated by wr_en. Register i loads wr_data on a rising clk edge only when its decoded enable is 1.
- Write latency: the new value is visible on a read port in the cycle after the edge, i.e. 1 clk.
- Write-enable rules:
  - wr_en=0: no register changes, whatever wr_addr and wr_data hold.
  - wr_addr=0 with wr_en=1: the write is discarded. Register 0 has no storage flop and always reads 0.
- Read ports: purely combinational 32:1 muxes. rd_dataN = reg[rd_addrN]. rd_addrN=0 always returns 0.
- Read/write collision: reading the address being written in the same cycle returns the OLD value. There is no write-through bypass; the single-cycle core writes at the end of the instruction.
- Dual read: both ports may address the same register simultaneously, and both return the same value.
- Reset mid-write: if rst asserts in the same cycle as a write, reset wins and the register is 0 afterwards.
- Reset release: the first write is accepted on the first rising edge after rst deasserts.
- X-handling: an unknown wr_addr with wr_en=0 must cause no state change.

Decomposition:
- Shared package/include (mips_defs):
  - REG_ADDR_W=5, DATA_W=32.
  - Named register constants: REG_ZERO=0, REG_SP=29, REG_RA=31.
- Sub-module decoder_5to32: combinational one-hot decoder with enable (en, addr[4:0] -> sel[31:0]). Reusable for memory-bank selection later.
- The read muxes stay inline.

Test Plan:
1. Reset: assert rst mid-simulation between clock edges -> rd_data1/rd_data2 read 0 for every address within the same delta, before the next clk edge.
2. Basic write/read: write 0xDEADBEEF to reg 8, then 0x12345678 to reg 31 -> next cycle, rd_addr1=8 gives 0xDEADBEEF and rd_addr2=31 gives 0x12345678. All other registers still read 0.
3. $zero protection: wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF -> rd_addr1=0 reads 0x00000000 afterwards.
4. Enable gating: wr_en=0, wr_addr=5, wr_data=0xA5A5A5A5 -> reg 5 unchanged at 0. Same transaction with wr_en=1 -> reads 0xA5A5A5A5 next cycle.
5. Collision: reg 9 holds 0x1; in the same cycle write 0x2 to reg 9 and read rd_addr1=rd_addr2=9 -> both read 0x1 before the edge, 0x2 after it.
6. Decode sweep: write i*0x01010101 to each register i=1..31 in turn, then read back on both ports -> every value matches, register 0 reads 0, and there is no aliasing.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS datapath definitions: widths and architectural register names.
package mips_defs;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int REG_NUM    = 1 << REG_ADDR_W;

  // Architectural register indices used by control and software conventions.
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

  // True when the index names the hardwired-zero register.
  function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] addr);
    return addr == REG_ZERO;
  endfunction

endpackage

// File: rtl/decoder_5to32.sv
// One-hot decoder with enable. With en low the output is all zeros whatever
// addr holds, so an unknown address cannot select anything while disabled.
module decoder_5to32 #(
  parameter int ADDR_W = 5
) (
  input  logic                   en,
  input  logic [ADDR_W-1:0]      addr,
  output logic [(1<<ADDR_W)-1:0] sel
);

  // Raise exactly one select line when enabled, none otherwise.
  always_comb begin
    sel = '0;
    if (en) begin
      sel[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_file_demux_32x32.sv
// MIPS general-purpose register file. One writeback port is steered to a single
// register through a one-hot write-enable demux; two combinational read ports
// feed rs/rt. Register 0 has no storage and always reads zero. Reads see the
// pre-edge contents: there is deliberately no write-through bypass.
module reg_file_demux_32x32 #(
  parameter int DATA_W = mips_defs::DATA_W,
  parameter int ADDR_W = mips_defs::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2
);

  import mips_defs::*;

  localparam int NUM_REGS = 1 << ADDR_W;

  // One-hot write enables, already gated by wr_en.
  logic [NUM_REGS-1:0] wr_sel;

  // Read view of the whole file; entry 0 is the constant-zero register.
  logic [DATA_W-1:0] reg_view [0:NUM_REGS-1];

  decoder_5to32 #(
    .ADDR_W (ADDR_W)
  ) u_wr_decoder (
    .en   (wr_en),
    .addr (wr_addr),
    .sel  (wr_sel)
  );

  assign reg_view[0] = '0;

  // Registers 1..N-1: each loads only when its decoded enable is set.
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    logic [DATA_W-1:0] q;

    // Asynchronous clear has priority over any write in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q <= '0;
      end else if (wr_sel[i]) begin
        q <= wr_data;
      end
    end

    assign reg_view[i] = q;
  end

  // Combinational read muxes; index 0 resolves to the zero entry.
  assign rd_data1 = reg_view[rd_addr1];
  assign rd_data2 = reg_view[rd_addr2];

  // The write demux must never select more than one register. Writes to
  // register 0 raise wr_sel[0], which is intentionally left without storage.
  a_wr_sel_onehot0 : assert property (@(posedge clk) disable iff (rst)
    $onehot0(wr_sel) && (wr_sel[0] == (wr_en && is_zero_reg(wr_addr))));

endmodule

// File: tb/tb_reg_file_demux_32x32.sv
// Directed bench for the register file: reset, write/read, zero protection,
// enable gating, collisions, async reset mid-write and a full decode sweep.
`timescale 1ns/100ps
module tb_reg_file_demux_32x32;

  import mips_defs::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr1;
  logic [AW-1:0] rd_addr2;
  logic [DW-1:0] rd_data1;
  logic [DW-1:0] rd_data2;

  int chk_cnt;
  int pass_cnt;

  reg_file_demux_32x32 #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
  endtask

  task automatic read_check(input string tag,
                            input logic [AW-1:0] a1, input logic [DW-1:0] e1,
                            input logic [AW-1:0] a2, input logic [DW-1:0] e2);
    rd_addr1 = a1;
    rd_addr2 = a2;
    #1;
    check({tag, "_p1"}, rd_data1, e1);
    check({tag, "_p2"}, rd_data2, e2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_addr1 = '0;
    rd_addr2 = '0;

    repeat (2) @(posedge clk);
    #1;
    read_check("reset_hold", 5'd8, 32'h0, REG_RA, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Basic write/read, all other registers untouched.
    write_reg(5'd8, 32'hDEADBEEF);
    write_reg(REG_RA, 32'h12345678);
    read_check("basic", 5'd8, 32'hDEADBEEF, REG_RA, 32'h12345678);
    for (int i = 0; i < 32; i++) begin
      if (i != 8 && i != 31) begin
        read_check($sformatf("untouched_%0d", i), 5'(i), 32'h0, 5'(31 - i),
                   (31 - i == 8) ? 32'hDEADBEEF : ((31 - i == 31) ? 32'h12345678 : 32'h0));
      end
    end

    // $zero protection.
    write_reg(REG_ZERO, 32'hFFFFFFFF);
    read_check("zero_protect", REG_ZERO, 32'h0, REG_ZERO, 32'h0);

    // Enable gating: disabled write does nothing, enabled one lands.
    @(negedge clk);
    wr_en = 1'b0; wr_addr = 5'd5; wr_data = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    read_check("en_gate_off", 5'd5, 32'h0, 5'd8, 32'hDEADBEEF);
    write_reg(5'd5, 32'hA5A5A5A5);
    read_check("en_gate_on", 5'd5, 32'hA5A5A5A5, REG_SP, 32'h0);

    // Unknown address with enable low: no state change.
    @(negedge clk);
    wr_en = 1'b0; wr_addr = 'x; wr_data = 32'h5A5A5A5A;
    @(posedge clk);
    #1;
    wr_addr = '0;
    read_check("x_addr_a", 5'd5, 32'hA5A5A5A5, 5'd8, 32'hDEADBEEF);
    read_check("x_addr_b", REG_RA, 32'h12345678, 5'd1, 32'h0);

    // Collision: old value before the edge, new value after.
    write_reg(5'd9, 32'h1);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h2;
    read_check("collide_pre", 5'd9, 32'h1, 5'd9, 32'h1);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    read_check("collide_post", 5'd9, 32'h2, 5'd9, 32'h2);

    // Decode sweep: distinct pattern in every register, no aliasing.
    for (int i = 1; i < 32; i++) begin
      write_reg(5'(i), 32'(i) * 32'h01010101);
    end
    for (int i = 0; i < 32; i++) begin
      read_check($sformatf("sweep_%0d", i),
                 5'(i), 32'(i) * 32'h01010101,
                 5'(31 - i), 32'(31 - i) * 32'h01010101);
    end

    // Async reset between edges, together with a pending write to reg 12.
    @(posedge clk);
    #1;
    rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'hCAFEF00D;
    #0.1;
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = 5'(i);
      rd_addr2 = 5'(31 - i);
      #0.1;
      check($sformatf("async_rst_p1_%0d", i), rd_data1, 32'h0);
      check($sformatf("async_rst_p2_%0d", i), rd_data2, 32'h0);
    end
    @(posedge clk);
    #1;
    read_check("rst_wins_write", 5'd12, 32'h0, 5'd8, 32'h0);

    // First edge after reset release accepts the still-pending write.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    read_check("rst_release", 5'd12, 32'hCAFEF00D, 5'd13, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  // Hard time limit so the run always ends with a summary.
  initial begin
    #100000;
    chk_cnt++;
    $display("FAIL timeout: got running expected finished");
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
